// File: rtl/tff_bank_sequencer_pkg.sv
// Shared definitions for the toggle-cell bank sequencer.
// Contents: FSM state encoding, manual command encoding, and an index-width helper.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        AUTO  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_CLR = 2'd0,
        CMD_SET = 2'd1,
        CMD_TOG = 2'd2
    } cmd_e;

    // Bit width needed to index n items; never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tff_bank_sequencer_if.sv
// Switch/LED bundle between the board pins and the sequencer.
// Ports: sw_clr/sw_set/sw_tog/sw_mode raw switches, sw_sel raw cell index,
//        led cell states, ptr auto pointer, busy (APPLY or AUTO), step auto-toggle pulse.
// master drives the switches; slave is the sequencer.
interface tff_bank_sequencer_if
    import tff_seq_pkg::*;
#(
    parameter int unsigned N_CELLS = 4
);
    localparam int unsigned SEL_W = idx_w(N_CELLS);

    logic               sw_clr;
    logic               sw_set;
    logic               sw_tog;
    logic               sw_mode;
    logic [SEL_W-1:0]   sw_sel;
    logic [N_CELLS-1:0] led;
    logic [SEL_W-1:0]   ptr;
    logic               busy;
    logic               step;

    modport master (
        output sw_clr, sw_set, sw_tog, sw_mode, sw_sel,
        input  led, ptr, busy, step
    );

    modport slave (
        input  sw_clr, sw_set, sw_tog, sw_mode, sw_sel,
        output led, ptr, busy, step
    );

endinterface

// File: rtl/tff_bank_sequencer_debounce.sv
// Switch conditioner: 2-flop synchroniser, debounce counter, rising-edge pulse.
// Ports: clk, rst_n (async active-low), raw switch in,
//        level (debounced level), rise (1-cycle pulse on debounced 0->1).
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // This sample is the last of DEB_CYCLES consecutive ones disagreeing with level.
    assign done = (cnt == CNT_W'(DEB_CYCLES - 1));

    // Synchroniser, run-length counter of disagreeing samples, registered rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                if (done) begin
                    level <= sync2;
                    rise  <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tff_bank_sequencer.sv
// Toggle-cell bank controller: manual clear/set/toggle of a selected cell from
// debounced switches, or an automatic toggle walking around the bank.
// Ports: clk, rst_n (async active-low), bus (slave modport): raw switches in,
//        led/ptr/busy/step out, all registered.
module tff_bank_sequencer
    import tff_seq_pkg::*;
#(
    parameter int unsigned N_CELLS    = 4,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned STEP_DIV   = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    tff_bank_sequencer_if.slave  bus
);
    localparam int unsigned SEL_W = idx_w(N_CELLS);
    localparam int unsigned CNT_W = idx_w(STEP_DIV);

    logic clr_rise, set_rise, tog_rise, mode_rise;
    logic clr_lvl, set_lvl, tog_lvl, mode_lvl;
    logic unused_levels;

    state_e             state_q, state_d;
    cmd_e               cmd_q, cmd_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_CELLS-1:0] led_q, led_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw_clr),  .level(clr_lvl),  .rise(clr_rise)
    );
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw_set),  .level(set_lvl),  .rise(set_rise)
    );
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_tog (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw_tog),  .level(tog_lvl),  .rise(tog_rise)
    );
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw_mode), .level(mode_lvl), .rise(mode_rise)
    );

    // Commands act on edges and mode acts on level; the other outputs are not needed.
    assign unused_levels = ^{clr_lvl, set_lvl, tog_lvl, mode_rise};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        sel_d   = sel_q;
        led_d   = led_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mode_lvl) begin
                    state_d = AUTO;
                    cnt_d   = '0;
                end else if (clr_rise || set_rise || tog_rise) begin
                    state_d = APPLY;
                    sel_d   = bus.sw_sel;
                    if (clr_rise) begin
                        cmd_d = CMD_CLR;
                    end else if (set_rise) begin
                        cmd_d = CMD_SET;
                    end else begin
                        cmd_d = CMD_TOG;
                    end
                end
            end

            APPLY: begin
                // An out-of-range sel matches no cell and leaves the bank untouched.
                for (int unsigned i = 0; i < N_CELLS; i++) begin
                    if (SEL_W'(i) == sel_q) begin
                        unique case (cmd_q)
                            CMD_CLR: led_d[i] = 1'b0;
                            CMD_SET: led_d[i] = 1'b1;
                            CMD_TOG: led_d[i] = ~led_q[i];
                            default: led_d[i] = led_q[i];
                        endcase
                    end
                end
                state_d = IDLE;
            end

            AUTO: begin
                if (!mode_lvl) begin
                    // Leaving auto drops any terminal count due this cycle.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (clr_rise) begin
                    led_d = '0;
                    ptr_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(STEP_DIV - 1)) begin
                    for (int unsigned i = 0; i < N_CELLS; i++) begin
                        if (SEL_W'(i) == ptr_q) begin
                            led_d[i] = ~led_q[i];
                        end
                    end
                    step_d = 1'b1;
                    ptr_d  = (ptr_q == SEL_W'(N_CELLS - 1)) ? '0 : ptr_q + SEL_W'(1);
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CMD_CLR;
            sel_q  <= '0;
            led_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            sel_q  <= sel_d;
            led_q  <= led_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            step_q <= step_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.ptr  = ptr_q;
    assign bus.busy = busy_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: directed vector table, hand-timed auto-mode
// corner sequences, an N_CELLS=3 instance for the out-of-range select, and a
// randomized run against a behavioural model of the switch-to-LED behaviour.
module tb_tff_bank_sequencer;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int SDIV = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tff_bank_sequencer_if #(.N_CELLS(4)) bus4 ();
    tff_bank_sequencer_if #(.N_CELLS(3)) bus3 ();

    tff_bank_sequencer #(.N_CELLS(4), .DEB_CYCLES(4), .STEP_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
    );

    tff_bank_sequencer #(.N_CELLS(3), .DEB_CYCLES(4), .STEP_DIV(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic       clr;
        logic       set;
        logic       tog;
        logic       mode;
        logic [1:0] sel;
        int         cycles;
        logic [3:0] led;
        logic [1:0] ptr;
        logic       busy;
    } vec_t;

    vec_t vt [12];

    // Behavioural model: switches seen two cycles late, a level flips once
    // DEB samples in a row disagree with it, commands act on level rises.
    int m_n;
    bit m_d1 [4];
    bit m_d2 [4];
    bit m_lvl [4];
    bit m_pulse [4];
    int m_ref [4];
    int m_state;   // 0 idle, 1 applying, 2 auto
    int m_cmd;     // 0 clr, 1 set, 2 tog
    int m_sel;
    int m_led;
    int m_ptr;
    int m_phase;
    bit m_step;

    function automatic void model_reset();
        m_n = 0;
        for (int k = 0; k < 4; k++) begin
            m_d1[k] = 0; m_d2[k] = 0; m_lvl[k] = 0; m_pulse[k] = 0; m_ref[k] = 0;
        end
        m_state = 0; m_cmd = 0; m_sel = 0; m_led = 0; m_ptr = 0; m_phase = 0; m_step = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] raw, input int sel_in);
        bit smp;
        m_n++;
        m_step = 0;
        case (m_state)
            1: begin
                if (m_sel < N) begin
                    if (m_cmd == 0)      m_led = m_led & ~(1 << m_sel);
                    else if (m_cmd == 1) m_led = m_led | (1 << m_sel);
                    else                 m_led = m_led ^ (1 << m_sel);
                end
                m_state = 0;
            end
            2: begin
                if (!m_lvl[3]) begin
                    m_state = 0;
                end else if (m_pulse[0]) begin
                    m_led = 0; m_ptr = 0; m_phase = 0;
                end else begin
                    m_phase++;
                    if (m_phase == SDIV) begin
                        m_led   = m_led ^ (1 << m_ptr);
                        m_step  = 1;
                        m_ptr   = (m_ptr + 1) % N;
                        m_phase = 0;
                    end
                end
            end
            default: begin
                if (m_lvl[3]) begin
                    m_state = 2;
                    m_phase = 0;
                end else if (m_pulse[0] || m_pulse[1] || m_pulse[2]) begin
                    m_cmd   = m_pulse[0] ? 0 : (m_pulse[1] ? 1 : 2);
                    m_sel   = sel_in;
                    m_state = 1;
                end
            end
        endcase
        for (int k = 0; k < 4; k++) begin
            smp        = m_d2[k];
            m_pulse[k] = 0;
            if (smp == m_lvl[k]) begin
                m_ref[k] = m_n;
            end else if (m_n - m_ref[k] >= DEB) begin
                m_lvl[k]   = smp;
                m_pulse[k] = smp;
                m_ref[k]   = m_n;
            end
            m_d2[k] = m_d1[k];
            m_d1[k] = raw[k];
        end
    endfunction

    logic [3:0] exp_led [5];
    logic [1:0] exp_ptr [5];
    logic [7:0] act_v, exp_v;

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0,  2, 4'b0000, 2'd0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2,  7, 4'b0000, 2'd0, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2,  1, 4'b0100, 2'd0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 10, 4'b0100, 2'd0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2,  8, 4'b0000, 2'd0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 10, 4'b0000, 2'd0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1,  8, 4'b0010, 2'd0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 10, 4'b0010, 2'd0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1,  3, 4'b0010, 2'd0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 10, 4'b0010, 2'd0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1,  8, 4'b0000, 2'd0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10, 4'b0000, 2'd0, 1'b0};

        exp_led[0] = 4'b0001; exp_ptr[0] = 2'd1;
        exp_led[1] = 4'b0011; exp_ptr[1] = 2'd2;
        exp_led[2] = 4'b0111; exp_ptr[2] = 2'd3;
        exp_led[3] = 4'b1111; exp_ptr[3] = 2'd0;
        exp_led[4] = 4'b1110; exp_ptr[4] = 2'd1;

        bus4.sw_clr = 0; bus4.sw_set = 0; bus4.sw_tog = 0; bus4.sw_mode = 0; bus4.sw_sel = '0;
        bus3.sw_clr = 0; bus3.sw_set = 0; bus3.sw_tog = 0; bus3.sw_mode = 0; bus3.sw_sel = '0;

        // Reset state
        tick(2);
        check("reset led",  32'(bus4.led),  32'h0);
        check("reset ptr",  32'(bus4.ptr),  32'h0);
        check("reset busy", 32'(bus4.busy), 32'h0);
        check("reset step", 32'(bus4.step), 32'h0);
        rst_n = 1'b1;

        // Directed manual-mode vectors
        for (int i = 0; i < 12; i++) begin
            bus4.sw_clr  = vt[i].clr;
            bus4.sw_set  = vt[i].set;
            bus4.sw_tog  = vt[i].tog;
            bus4.sw_mode = vt[i].mode;
            bus4.sw_sel  = vt[i].sel;
            tick(vt[i].cycles);
            check($sformatf("vec%0d led", i),  32'(bus4.led),  32'(vt[i].led));
            check($sformatf("vec%0d ptr", i),  32'(bus4.ptr),  32'(vt[i].ptr));
            check($sformatf("vec%0d busy", i), 32'(bus4.busy), 32'(vt[i].busy));
        end

        // Auto mode: a step every SDIV cycles, pointer wraps
        bus4.sw_mode = 1'b1;
        tick(7);
        check("auto entry busy", 32'(bus4.busy), 32'h1);
        check("auto entry led",  32'(bus4.led),  32'h0);
        for (int k = 0; k < 5; k++) begin
            tick(7);
            check($sformatf("auto pre-step%0d step", k), 32'(bus4.step), 32'h0);
            tick(1);
            check($sformatf("auto step%0d step", k), 32'(bus4.step), 32'h1);
            check($sformatf("auto step%0d led", k),  32'(bus4.led),  32'(exp_led[k]));
            check($sformatf("auto step%0d ptr", k),  32'(bus4.ptr),  32'(exp_ptr[k]));
        end

        // CLR pulse landing on the terminal count
        tick(1);
        bus4.sw_clr = 1'b1;
        tick(6);
        check("clr-tc pre led", 32'(bus4.led), 32'hE);
        tick(1);
        check("clr-tc led",  32'(bus4.led),  32'h0);
        check("clr-tc ptr",  32'(bus4.ptr),  32'h0);
        check("clr-tc step", 32'(bus4.step), 32'h0);
        check("clr-tc busy", 32'(bus4.busy), 32'h1);
        tick(8);
        check("after clr step", 32'(bus4.step), 32'h1);
        check("after clr led",  32'(bus4.led),  32'h1);
        check("after clr ptr",  32'(bus4.ptr),  32'h1);

        // Mode falls on a terminal count: toggle dropped, ptr and led held
        tick(1);
        bus4.sw_clr  = 1'b0;
        bus4.sw_mode = 1'b0;
        tick(6);
        check("mode-off pre busy", 32'(bus4.busy), 32'h1);
        tick(1);
        check("mode-off busy", 32'(bus4.busy), 32'h0);
        check("mode-off led",  32'(bus4.led),  32'h1);
        check("mode-off ptr",  32'(bus4.ptr),  32'h1);
        check("mode-off step", 32'(bus4.step), 32'h0);
        tick(10);
        check("idle hold led", 32'(bus4.led), 32'h1);
        check("idle hold ptr", 32'(bus4.ptr), 32'h1);

        // Three-cell bank: select 3 is out of range
        bus3.sw_sel = 2'd3;
        bus3.sw_tog = 1'b1;
        tick(7);
        check("n3 oob busy", 32'(bus3.busy), 32'h1);
        tick(1);
        check("n3 oob led",       32'(bus3.led),  32'h0);
        check("n3 oob idle busy", 32'(bus3.busy), 32'h0);
        bus3.sw_tog = 1'b0;
        tick(10);
        bus3.sw_sel = 2'd2;
        bus3.sw_tog = 1'b1;
        tick(8);
        check("n3 sel2 led", 32'(bus3.led), 32'h4);
        bus3.sw_tog = 1'b0;

        // Randomized run against the model
        bus4.sw_clr = 0; bus4.sw_set = 0; bus4.sw_tog = 0; bus4.sw_mode = 0; bus4.sw_sel = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0)  bus4.sw_clr  = ~bus4.sw_clr;
            if ($urandom_range(7) == 0)  bus4.sw_set  = ~bus4.sw_set;
            if ($urandom_range(7) == 0)  bus4.sw_tog  = ~bus4.sw_tog;
            if ($urandom_range(79) == 0) bus4.sw_mode = ~bus4.sw_mode;
            bus4.sw_sel = 2'($urandom_range(3));
            tick(1);
            model_edge({bus4.sw_mode, bus4.sw_tog, bus4.sw_set, bus4.sw_clr}, int'(bus4.sw_sel));
            act_v = {bus4.led, bus4.ptr, bus4.busy, bus4.step};
            exp_v = {4'(m_led), 2'(m_ptr), (m_state != 0), m_step};
            check($sformatf("rand cyc%0d {led,ptr,busy,step}", c), 32'(act_v), 32'(exp_v));
        end

        // Asynchronous reset in the middle of an auto step
        bus4.sw_clr = 0; bus4.sw_set = 0; bus4.sw_tog = 0; bus4.sw_mode = 0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        bus4.sw_mode = 1'b1;
        tick(15);
        check("pre-reset step", 32'(bus4.step), 32'h1);
        check("pre-reset led",  32'(bus4.led),  32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset led",  32'(bus4.led),  32'h0);
        check("async reset ptr",  32'(bus4.ptr),  32'h0);
        check("async reset busy", 32'(bus4.busy), 32'h0);
        check("async reset step", 32'(bus4.step), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
